mem_interface_unit: RTL

Memory interface unit between the instruction unit and byte-wide main memory. Accepts one load (8-bit) or store (16-bit result) request at a time from the instruction unit and runs the byte transfers on a req/resp memory bus. For a load it returns the byte on `data`; for a store it writes two bytes, little-endian. It reports completion with a one-cycle `mem_done` pulse, and recovers from a memory that never responds by timing out.

---
 rtl/mem_interface_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_interface_unit.sv
// mem_interface_unit: bridges one load/store request from the instruction unit
// onto a byte-wide req/resp memory bus. Loads fetch one byte; stores write a
// 16-bit value as two bytes, little-endian. A per-byte wait counter recovers
// from a memory that never answers.
module mem_interface_unit #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       result,
  output logic [7:0]        data,
  output logic              mem_done,
  output logic              mem_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_LO,
    S_WR_HI,
    S_DONE,
    S_RELEASE
  } state_t;

  // The counter only ever needs to reach TIMEOUT-1 before the FSM leaves.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       res_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              byte_state;
  logic              timed_out;

  assign byte_state = (state == S_RD) || (state == S_WR_LO) || (state == S_WR_HI);

  // Fires in the TIMEOUT-th consecutive cycle without a response.
  assign timed_out = (TIMEOUT != 0) && byte_state && !mem_resp && (wait_cnt == CNT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its peers, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; load wins when both requests arrive together.
  // NOTE: the default assignment up front keeps this purely combinational;
  // leaving any path unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load)       state_nxt = S_RD;
        else if (store) state_nxt = S_WR_LO;
      end
      S_RD: begin
        if (mem_resp || timed_out) state_nxt = S_DONE;
      end
      S_WR_LO: begin
        if (mem_resp)       state_nxt = S_WR_HI;
        else if (timed_out) state_nxt = S_DONE;
      end
      S_WR_HI: begin
        if (mem_resp || timed_out) state_nxt = S_DONE;
      end
      S_DONE:    state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (!load && !store) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Request capture, load data, and error flag for the current transaction.
  // NOTE: the captured request registers are reset too, so the bus outputs
  // derived from them are defined zeros straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      data   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (load || store) begin
            addr_q <= addr;
            res_q  <= result;
            err_q  <= load && store;
          end
        end
        S_RD: begin
          if (mem_resp) begin
            data <= mem_rdata;
          end else if (timed_out) begin
            data  <= 8'hFF;
            err_q <= 1'b1;
          end
        end
        S_WR_LO, S_WR_HI: begin
          if (timed_out) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-byte wait counter: cleared outside byte states and on each response,
  // so it restarts from zero on entry to every byte state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      wait_cnt <= '0;
    else if (!byte_state || mem_resp) wait_cnt <= '0;
    else if (TIMEOUT != 0)          wait_cnt <= wait_cnt + 1'b1;
  end

  // Bus and status outputs decoded from the state and captured request.
  always_comb begin
    mem_req   = byte_state;
    mem_we    = (state == S_WR_LO) || (state == S_WR_HI);
    mem_addr  = addr_q;
    mem_wdata = 8'h00;
    mem_done  = (state == S_DONE);
    mem_err   = (state == S_DONE) && err_q;
    busy      = (state != S_IDLE);
    if (state == S_WR_LO) begin
      mem_wdata = res_q[7:0];
    end else if (state == S_WR_HI) begin
      mem_addr  = addr_q + ADDR_W'(1);
      mem_wdata = res_q[15:8];
    end
  end

endmodule
